// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B - Bin, LSB first, with valid/ready on both sides.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Ovf
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             bout_q, bout_d;
  logic             ovfo_q, ovfo_d;
  logic             vld_q, vld_d;

  logic fs_d, fs_bout;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    ovf_d   = ovf_q;
    dout_d  = dout_q;
    bout_d  = bout_q;
    ovfo_d  = ovfo_q;
    vld_d   = vld_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = {fs_d, res_q[WIDTH-1:1]};
        br_d  = fs_bout;
        if (cnt_q == CNT_LAST) begin
          // Overflow iff the borrow into the sign bit differs from the borrow out of it.
          ovf_d   = fs_bout ^ br_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        // First DONE cycle publishes into the output registers, which then hold
        // the result across IDLE while the working registers take new operands.
        if (!vld_q) begin
          dout_d = res_q;
          bout_d = br_q;
          ovfo_d = ovf_q;
          vld_d  = 1'b1;
        end else if (out_ready) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
      bout_q  <= 1'b0;
      ovfo_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
      bout_q  <= bout_d;
      ovfo_q  <= ovfo_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = vld_q;
  assign D         = dout_q;
  assign Bout      = bout_q;
  assign Ovf       = ovfo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: fixed vectors, random operands against an arithmetic model, handshake corners.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_s = '0;
  logic [W-1:0] b_s = '0;
  logic         bin_s = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] d_o;
  logic         bout_o;
  logic         ovf_o;

  int total = 0;
  int bad = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_s),
    .B         (b_s),
    .Bin       (bin_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (d_o),
    .Bout      (bout_o),
    .Ovf       (ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: integer arithmetic on the unsigned and signed readings of the operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int ud, sd;
    ud = int'(a) - int'(b) - int'(bi);
    sd = int'($signed(a)) - int'($signed(b)) - int'(bi);
    d  = W'(ud);
    bo = (ud < 0);
    ov = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
  endtask

  // Issue one operation; returns the result and accept-to-valid latency. If hs is set
  // (and out_ready is high) completes the output handshake and checks the return to IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input bit hs, output logic [W-1:0] d, output logic bo,
                        output logic ov, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    a_s = a; b_s = b; bin_s = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    d = d_o; bo = bout_o; ov = ovf_o;
    if (hs && out_ready) begin
      @(posedge clk); #1;
      chk("post_hs_out_valid", 32'(out_valid), 32'd0);
      chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    vec_t vecs[8];
    logic [W-1:0] gd, ed, hd;
    logic gb, go, eb, eo, hb, ho;
    int lat;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hC3, 8'hC3, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_D", 32'(d_o), 32'd0);
    chk("rst_Bout", 32'(bout_o), 32'd0);
    chk("rst_Ovf", 32'(ovf_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Fixed vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bi, 1'b1, gd, gb, go, lat);
      chk($sformatf("vec%0d_D", i), 32'(gd), 32'(vecs[i].d));
      chk($sformatf("vec%0d_Bout", i), 32'(gb), 32'(vecs[i].bo));
      chk($sformatf("vec%0d_Ovf", i), 32'(go), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(W + 1));
    end

    // Random operands against the model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rbi;
      ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      model(ra, rb, rbi, ed, eb, eo);
      run_op(ra, rb, rbi, 1'b1, gd, gb, go, lat);
      chk($sformatf("rnd%0d_D", i), 32'(gd), 32'(ed));
      chk($sformatf("rnd%0d_Bout", i), 32'(gb), 32'(eb));
      chk($sformatf("rnd%0d_Ovf", i), 32'(go), 32'(eo));
    end

    // Backpressure in DONE with fresh operands offered every other cycle
    out_ready = 1'b0;
    run_op(8'h80, 8'h01, 1'b0, 1'b0, hd, hb, ho, lat);
    chk("bp_D", 32'(hd), 32'h7F);
    chk("bp_Ovf", 32'(ho), 32'd1);
    for (int i = 0; i < 5; i++) begin
      a_s = W'($urandom); b_s = W'($urandom); bin_s = 1'b1;
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_D", 32'(d_o), 32'(hd));
      chk("bp_hold_Bout", 32'(bout_o), 32'(hb));
      chk("bp_hold_Ovf", 32'(ovf_o), 32'(ho));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_not_queued", 32'(in_ready), 32'd1);
    chk("bp_result_kept_D", 32'(d_o), 32'(hd));

    // out_ready while idle does nothing
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Reset mid-operation, after leaving a nonzero result on the outputs
    run_op(8'h00, 8'h00, 1'b1, 1'b1, gd, gb, go, lat);
    chk("pre_rst_D", 32'(gd), 32'hFF);
    a_s = 8'h33; b_s = 8'h11; bin_s = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_D", 32'(d_o), 32'd0);
    chk("midrst_Bout", 32'(bout_o), 32'd0);
    chk("midrst_Ovf", 32'(ovf_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, 1'b1, gd, gb, go, lat);
    chk("after_rst_D", 32'(gd), 32'h0F);
    chk("after_rst_Bout", 32'(gb), 32'd0);
    chk("after_rst_Ovf", 32'(go), 32'd0);
    chk("after_rst_latency", 32'(lat), 32'(W + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
